// File: rtl/sd_uart_cmd_engine.sv
// UART command engine for the SD host controller.
// Parses A5/CMD/CHK frames from the RX byte stream and answers with a framed,
// XOR-checksummed response (register snapshot, controller info, ACK or NAK).
module sd_uart_cmd_engine #(
    parameter logic [7:0] START_BYTE  = 8'hA5,
    parameter int         REG_W       = 128,
    parameter int         TIMEOUT_CYC = 100000,
    parameter logic [7:0] CTRL_VER    = 8'h01
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_rx_valid,
    input  logic [7:0]       i_rx_data,
    input  logic             i_tx_ready,
    output logic             o_tx_valid,
    output logic [7:0]       o_tx_data,
    input  logic [REG_W-1:0] i_cid_reg,
    input  logic [REG_W-1:0] i_csd_reg,
    input  logic [31:0]      i_status_reg,
    output logic             o_sd_reset_req,
    output logic             o_busy,
    output logic             o_frame_err
);

    localparam int NBYTES = REG_W / 8;
    localparam int BUF_W  = (REG_W > 40) ? REG_W : 40;
    // The counter must also hold the 5-byte controller-info length when REG_W is small.
    localparam int MAXLEN = (NBYTES > 5) ? NBYTES : 5;
    localparam int CNT_W  = $clog2(MAXLEN + 1);
    localparam int TC_W   = $clog2(TIMEOUT_CYC);

    localparam logic [7:0] CMD_RESET     = 8'h20;
    localparam logic [7:0] CMD_SD_INFO   = 8'h15;
    localparam logic [7:0] CMD_CSD       = 8'h16;
    localparam logic [7:0] CMD_CTRL_INFO = 8'h1B;
    localparam logic [7:0] CMD_NAK       = 8'hEE;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_CMD,
        S_GET_CHK,
        S_SEND_HDR,
        S_SEND_CMD,
        S_SEND_LEN,
        S_SEND_DATA,
        S_SEND_SUM
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [7:0]         r_cmd;
    logic [7:0]         r_cmd_out;
    logic [7:0]         r_len;
    logic [CNT_W-1:0]   r_cnt;
    logic [BUF_W-1:0]   r_buf;
    logic [7:0]         r_sum;
    logic [TC_W-1:0]    r_idle_cnt;
    logic               r_tx_valid;
    logic               r_sd_reset_req;
    logic               r_frame_err;

    logic               w_send;
    logic               w_get;
    logic               w_hs;
    logic               w_timeout;
    logic [BUF_W-1:0]   w_cid_ext;
    logic [BUF_W-1:0]   w_csd_ext;
    logic [BUF_W-1:0]   w_ctrl_ext;

    assign w_send = (r_state == S_SEND_HDR) || (r_state == S_SEND_CMD) ||
                    (r_state == S_SEND_LEN) || (r_state == S_SEND_DATA) ||
                    (r_state == S_SEND_SUM);
    assign w_get  = (r_state == S_GET_CMD) || (r_state == S_GET_CHK);
    assign w_hs   = r_tx_valid && i_tx_ready;
    assign w_timeout = w_get && !i_rx_valid &&
                       (r_idle_cnt == TC_W'(TIMEOUT_CYC - 1));

    // Payload sources are left-aligned in the buffer so the MSB byte is always on top.
    assign w_cid_ext  = BUF_W'(i_cid_reg) << (BUF_W - REG_W);
    assign w_csd_ext  = BUF_W'(i_csd_reg) << (BUF_W - REG_W);
    assign w_ctrl_ext = BUF_W'({CTRL_VER, i_status_reg}) << (BUF_W - 40);

    assign o_tx_valid     = r_tx_valid;
    assign o_sd_reset_req = r_sd_reset_req;
    assign o_frame_err    = r_frame_err;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode: RX framing, timeout abort and TX byte sequencing.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_rx_valid && (i_rx_data == START_BYTE)) w_next = S_GET_CMD;
            end
            S_GET_CMD: begin
                if (i_rx_valid)     w_next = S_GET_CHK;
                else if (w_timeout) w_next = S_IDLE;
            end
            S_GET_CHK: begin
                if (i_rx_valid)     w_next = S_SEND_HDR;
                else if (w_timeout) w_next = S_IDLE;
            end
            S_SEND_HDR: begin
                if (w_hs) w_next = S_SEND_CMD;
            end
            S_SEND_CMD: begin
                if (w_hs) w_next = S_SEND_LEN;
            end
            S_SEND_LEN: begin
                if (w_hs) w_next = (r_len == 8'h00) ? S_SEND_SUM : S_SEND_DATA;
            end
            S_SEND_DATA: begin
                if (w_hs && (r_cnt == CNT_W'(1))) w_next = S_SEND_SUM;
            end
            S_SEND_SUM: begin
                if (w_hs) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Output decode: the byte on the TX bus is chosen by the current SEND state.
    always_comb begin
        o_tx_data = 8'h00;
        o_busy    = (r_state != S_IDLE);
        if (r_tx_valid) begin
            case (r_state)
                S_SEND_HDR:  o_tx_data = START_BYTE;
                S_SEND_CMD:  o_tx_data = r_cmd_out;
                S_SEND_LEN:  o_tx_data = r_len;
                S_SEND_DATA: o_tx_data = r_buf[BUF_W-1 -: 8];
                S_SEND_SUM:  o_tx_data = r_sum;
                default:     o_tx_data = 8'h00;
            endcase
        end
    end

    // Datapath: command latch, snapshot, checksum, counters, TX handshake and pulses.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cmd          <= 8'h00;
            r_cmd_out      <= 8'h00;
            r_len          <= 8'h00;
            r_cnt          <= '0;
            r_buf          <= '0;
            r_sum          <= 8'h00;
            r_idle_cnt     <= '0;
            r_tx_valid     <= 1'b0;
            r_sd_reset_req <= 1'b0;
            r_frame_err    <= 1'b0;
        end else begin
            r_sd_reset_req <= 1'b0;
            r_frame_err    <= 1'b0;

            if (w_get && !i_rx_valid && !w_timeout) r_idle_cnt <= r_idle_cnt + TC_W'(1);
            else                                    r_idle_cnt <= '0;

            if (w_timeout)            r_frame_err <= 1'b1;
            if (w_send && i_rx_valid) r_frame_err <= 1'b1;

            if ((r_state == S_GET_CMD) && i_rx_valid) r_cmd <= i_rx_data;

            if ((r_state == S_GET_CHK) && i_rx_valid) begin
                r_sum     <= 8'h00;
                r_len     <= 8'h00;
                r_cnt     <= '0;
                r_cmd_out <= r_cmd;
                if (i_rx_data != ~r_cmd) begin
                    r_cmd_out   <= CMD_NAK;
                    r_frame_err <= 1'b1;
                end else begin
                    case (r_cmd)
                        CMD_RESET: begin
                            r_sd_reset_req <= 1'b1;
                        end
                        CMD_SD_INFO: begin
                            r_buf <= w_cid_ext;
                            r_len <= 8'(NBYTES);
                            r_cnt <= CNT_W'(NBYTES);
                        end
                        CMD_CSD: begin
                            r_buf <= w_csd_ext;
                            r_len <= 8'(NBYTES);
                            r_cnt <= CNT_W'(NBYTES);
                        end
                        CMD_CTRL_INFO: begin
                            r_buf <= w_ctrl_ext;
                            r_len <= 8'd5;
                            r_cnt <= CNT_W'(5);
                        end
                        default: begin
                            r_cmd_out   <= CMD_NAK;
                            r_frame_err <= 1'b1;
                        end
                    endcase
                end
            end

            if (w_send) begin
                if (!r_tx_valid)     r_tx_valid <= 1'b1;
                else if (i_tx_ready) r_tx_valid <= 1'b0;
            end else begin
                r_tx_valid <= 1'b0;
            end

            if (w_hs) begin
                r_sum <= r_sum ^ o_tx_data;
                if (r_state == S_SEND_DATA) begin
                    r_buf <= r_buf << 8;
                    if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_sd_uart_cmd_engine.sv
// Scoreboard bench for sd_uart_cmd_engine: three instances (REG_W 128/8/2040)
// share one stimulus path; only the selected instance sees RX bytes and TX ready.
module tb_sd_uart_cmd_engine;

    localparam int         TO  = 40;
    localparam logic [7:0] SB  = 8'hA5;
    localparam logic [7:0] VER = 8'h01;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          tx_ready;
    logic [31:0]   status;
    logic [127:0]  cidA, csdA;
    logic [7:0]    cidB, csdB;
    logic [2039:0] cidC, csdC;
    int            sel;

    logic       tvA, tvB, tvC, rrA, rrB, rrC, bzA, bzB, bzC, feA, feB, feC;
    logic [7:0] tdA, tdB, tdC;
    logic       mTv, mRr, mBusy, mFe;
    logic [7:0] mTd;

    logic [7:0] expQ[$];
    logic [7:0] pay[$];
    int nTotal = 0;
    int nBad   = 0;
    int feCnt  = 0;
    int rrCnt  = 0;

    always #5 clk = ~clk;

    sd_uart_cmd_engine #(.START_BYTE(SB), .REG_W(128), .TIMEOUT_CYC(TO), .CTRL_VER(VER)) dutA (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx_valid(rx_valid && sel == 0), .i_rx_data(rx_data),
        .i_tx_ready(tx_ready && sel == 0), .o_tx_valid(tvA), .o_tx_data(tdA),
        .i_cid_reg(cidA), .i_csd_reg(csdA), .i_status_reg(status),
        .o_sd_reset_req(rrA), .o_busy(bzA), .o_frame_err(feA));

    sd_uart_cmd_engine #(.START_BYTE(SB), .REG_W(8), .TIMEOUT_CYC(TO), .CTRL_VER(VER)) dutB (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx_valid(rx_valid && sel == 1), .i_rx_data(rx_data),
        .i_tx_ready(tx_ready && sel == 1), .o_tx_valid(tvB), .o_tx_data(tdB),
        .i_cid_reg(cidB), .i_csd_reg(csdB), .i_status_reg(status),
        .o_sd_reset_req(rrB), .o_busy(bzB), .o_frame_err(feB));

    sd_uart_cmd_engine #(.START_BYTE(SB), .REG_W(2040), .TIMEOUT_CYC(TO), .CTRL_VER(VER)) dutC (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx_valid(rx_valid && sel == 2), .i_rx_data(rx_data),
        .i_tx_ready(tx_ready && sel == 2), .o_tx_valid(tvC), .o_tx_data(tdC),
        .i_cid_reg(cidC), .i_csd_reg(csdC), .i_status_reg(status),
        .o_sd_reset_req(rrC), .o_busy(bzC), .o_frame_err(feC));

    // Route the selected instance's outputs to the monitor.
    always_comb begin
        case (sel)
            1:       begin mTv = tvB; mTd = tdB; mRr = rrB; mBusy = bzB; mFe = feB; end
            2:       begin mTv = tvC; mTd = tdC; mRr = rrC; mBusy = bzC; mFe = feC; end
            default: begin mTv = tvA; mTd = tdA; mRr = rrA; mBusy = bzA; mFe = feA; end
        endcase
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nTotal++;
        if (got !== exp) begin
            nBad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pop and compare every accepted TX byte; an empty queue yields an unmatchable sentinel.
    always @(negedge clk) begin
        logic [31:0] e;
        if (rst_n) begin
            if (mFe) feCnt++;
            if (mRr) rrCnt++;
            if (mTv && tx_ready) begin
                e = (expQ.size() != 0) ? {24'h0, expQ.pop_front()} : 32'h100;
                checkOutput("tx byte", {24'h0, mTd}, e);
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] b);
        @(posedge clk); #1;
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    // Queue the expected response frame built from cmd and the current payload list.
    task automatic pushFrame(input logic [7:0] cmd);
        logic [7:0] s;
        s = SB ^ cmd ^ 8'(pay.size());
        expQ.push_back(SB);
        expQ.push_back(cmd);
        expQ.push_back(8'(pay.size()));
        foreach (pay[i]) begin
            expQ.push_back(pay[i]);
            s = s ^ pay[i];
        end
        expQ.push_back(s);
    endtask

    // Pack the payload list MSB-first into the selected instance's CID or CSD input.
    task automatic loadReg(input bit isCsd);
        int nb;
        nb = pay.size();
        for (int i = 0; i < nb; i++) begin
            case (sel)
                1: if (isCsd) csdB[(nb-1-i)*8 +: 8] = pay[i]; else cidB[(nb-1-i)*8 +: 8] = pay[i];
                2: if (isCsd) csdC[(nb-1-i)*8 +: 8] = pay[i]; else cidC[(nb-1-i)*8 +: 8] = pay[i];
                default: if (isCsd) csdA[(nb-1-i)*8 +: 8] = pay[i]; else cidA[(nb-1-i)*8 +: 8] = pay[i];
            endcase
        end
    endtask

    task automatic randomPay(input int nb);
        pay.delete();
        for (int i = 0; i < nb; i++) pay.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic waitDrain(input string tag);
        int n;
        n = 0;
        while ((expQ.size() != 0 || mBusy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, " drained"}, expQ.size(), 0);
        checkOutput({tag, " idle"}, {31'h0, mBusy}, 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic waitQueueBelow(input int lim);
        int n;
        n = 0;
        while (expQ.size() > lim && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reached mid payload", {31'h0, expQ.size() <= lim}, 1);
    endtask

    // Tests 1-3 for whichever instance is selected.
    task automatic runBasic(input int nb);
        int fe0, rr0;
        if (sel == 0) begin
            pay.delete();
            for (int i = 0; i < 16; i++) pay.push_back(8'(i * 17));
        end else begin
            randomPay(nb);
        end
        loadReg(1'b0);
        applyStimulus(SB); applyStimulus(8'h15); applyStimulus(8'hEA);
        pushFrame(8'h15);
        waitDrain("sd info");

        pay.delete();
        rr0 = rrCnt;
        applyStimulus(SB); applyStimulus(8'h20); applyStimulus(8'hDF);
        checkOutput("reset req after chk", {31'h0, mRr}, 1);
        pushFrame(8'h20);
        waitDrain("reset ack");
        checkOutput("reset req pulses", rrCnt - rr0, 1);
        checkOutput("reset ack sum", 32'(SB ^ 8'h20), 32'h85);

        fe0 = feCnt;
        applyStimulus(SB); applyStimulus(8'h15); applyStimulus(8'h00);
        pushFrame(8'hEE);
        waitDrain("nak");
        checkOutput("nak frame_err pulses", feCnt - fe0, 1);
    endtask

    initial begin
        int fe0, n;
        logic [7:0] held;
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b1;
        status   = 32'hDEADBEEF;
        sel      = 0;
        cidA = '0; csdA = '0; cidB = '0; csdB = '0; cidC = '0; csdC = '0;
        #1;
        checkOutput("reset tx_valid", {31'h0, mTv}, 0);
        checkOutput("reset tx_data", {24'h0, mTd}, 0);
        checkOutput("reset busy", {31'h0, mBusy}, 0);
        checkOutput("reset frame_err", {31'h0, mFe}, 0);
        checkOutput("reset sd_reset_req", {31'h0, mRr}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] tests 1-3, REG_W=128");
        runBasic(16);

        // Stray non-start byte in IDLE is ignored silently.
        fe0 = feCnt;
        applyStimulus(8'h15);
        repeat (4) @(negedge clk);
        checkOutput("idle stray busy", {31'h0, mBusy}, 0);
        checkOutput("idle stray frame_err", feCnt - fe0, 0);

        $display("[TB] test 4, timeout then controller info");
        fe0 = feCnt;
        applyStimulus(SB); applyStimulus(8'h1B);
        checkOutput("busy in get_chk", {31'h0, mBusy}, 1);
        n = 0;
        while (feCnt == fe0 && n < TO + 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("timeout fired", feCnt - fe0, 1);
        checkOutput("timeout window", {31'h0, (n >= TO - 2) && (n <= TO + 2)}, 1);
        repeat (2) @(negedge clk);
        checkOutput("idle after timeout", {31'h0, mBusy}, 0);
        checkOutput("no tx after timeout", expQ.size(), 0);
        pay.delete();
        pay.push_back(VER);
        for (int i = 3; i >= 0; i--) pay.push_back(status[i*8 +: 8]);
        applyStimulus(SB); applyStimulus(8'h1B); applyStimulus(8'hE4);
        pushFrame(8'h1B);
        status = 32'h12345678;
        waitDrain("ctrl info");

        $display("[TB] test 5, stall, snapshot and dropped RX byte");
        randomPay(16);
        loadReg(1'b0);
        applyStimulus(SB); applyStimulus(8'h15); applyStimulus(8'hEA);
        pushFrame(8'h15);
        cidA = ~cidA;
        waitQueueBelow(12);
        fe0 = feCnt;
        applyStimulus(8'h33);
        repeat (2) @(negedge clk);
        checkOutput("dropped rx frame_err", feCnt - fe0, 1);
        @(posedge clk); #1;
        tx_ready = 1'b0;
        n = 0;
        @(negedge clk);
        while (!mTv && n < 5) begin
            @(negedge clk);
            n++;
        end
        held = mTd;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            checkOutput("stall tx_valid held", {31'h0, mTv}, 1);
            checkOutput("stall tx_data held", {24'h0, mTd}, {24'h0, held});
        end
        @(posedge clk); #1;
        tx_ready = 1'b1;
        waitDrain("stalled sd info");

        $display("[TB] test 6, reset during payload");
        sel = 0;
        randomPay(16);
        loadReg(1'b1);
        applyStimulus(SB); applyStimulus(8'h16); applyStimulus(8'hE9);
        pushFrame(8'h16);
        waitQueueBelow(8);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("mid reset tx_valid", {31'h0, mTv}, 0);
        checkOutput("mid reset busy", {31'h0, mBusy}, 0);
        checkOutput("mid reset tx_data", {24'h0, mTd}, 0);
        expQ.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("no resume after reset", {31'h0, mTv}, 0);
        applyStimulus(SB); applyStimulus(8'h16); applyStimulus(8'hE9);
        pushFrame(8'h16);
        waitDrain("csd after reset");

        $display("[TB] tests 1-3, REG_W=8");
        sel = 1;
        repeat (2) @(negedge clk);
        runBasic(1);

        $display("[TB] tests 1-3, REG_W=2040");
        sel = 2;
        repeat (2) @(negedge clk);
        runBasic(255);

        $display("test done: total=%0d bad=%0d", nTotal, nBad);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

endmodule
